// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a one-entry skid buffer and flush.
// Decoded fields are taken combinationally from the OUT instruction register.
module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [3:0]            instr_op,
  output logic [3:0]            alu_op,
  output logic [2:0]            branch_op,
  output logic [DATA_WIDTH-1:0] const_alu,
  output logic [DATA_WIDTH-1:0] const16,
  output logic [DATA_WIDTH-1:0] const16u,
  output logic [DATA_WIDTH-1:0] const27,
  output logic [3:0]            areg,
  output logic [3:0]            breg,
  output logic [3:0]            dreg,
  output logic                  he,
  output logic                  oe,
  output logic                  sig,
  output logic [15:0]           drop_count
);

  // state   | meaning
  // S_EMPTY | nothing held (skid_valid=0, out_valid=0)
  // S_ONE   | OUT holds an instruction, SKID empty
  // S_FULL  | OUT and SKID both hold instructions, input stalled
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;

  logic [31:0]         r_out_instr;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic [31:0]         r_skid_instr;
  logic [PC_WIDTH-1:0] r_skid_pc;
  logic [15:0]         r_drop_count;

  logic        w_out_valid;
  logic        w_skid_valid;
  logic        w_accept;
  logic        w_deliver;
  logic        w_out_free;
  logic        w_out_from_skid;
  logic        w_load_out;
  logic        w_load_skid;
  logic [1:0]  w_occ;
  logic [1:0]  w_occ_nxt;
  logic [1:0]  w_drop_inc;
  logic [16:0] w_drop_sum;

  // State register; in_ready is registered from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Next state follows occupancy: entries held - delivered + accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_occ       = {1'b0, w_out_valid} + {1'b0, w_skid_valid};
    w_occ_nxt   = w_occ - {1'b0, w_deliver} + {1'b0, w_accept};
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (w_occ_nxt)
        2'd0:    w_state_nxt = S_EMPTY;
        2'd1:    w_state_nxt = S_ONE;
        default: w_state_nxt = S_FULL;
      endcase
    end
  end

  always_comb begin
    w_out_valid     = (r_state != S_EMPTY);
    w_skid_valid    = (r_state == S_FULL);
    w_accept        = in_valid && r_in_ready;
    w_deliver       = w_out_valid && out_ready;
    w_out_free      = !w_out_valid || out_ready;
    w_out_from_skid = w_out_free && w_skid_valid;
    w_load_out      = w_out_free && (w_skid_valid || w_accept);
    w_load_skid     = w_accept && (!w_out_free || w_skid_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_instr  <= 32'h0;
      r_out_pc     <= '0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= '0;
    end else if (!flush) begin
      if (w_load_out) begin
        r_out_instr <= w_out_from_skid ? r_skid_instr : instr;
        r_out_pc    <= w_out_from_skid ? r_skid_pc    : in_pc;
      end
      if (w_load_skid) begin
        r_skid_instr <= instr;
        r_skid_pc    <= in_pc;
      end
    end
  end

  // A handshaken OUT entry counts as delivered even under flush.
  always_comb begin
    w_drop_inc = {1'b0, (w_out_valid && !out_ready)} + {1'b0, w_skid_valid}
               + {1'b0, w_accept};
    w_drop_sum = {1'b0, r_drop_count} + {15'b0, w_drop_inc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= 16'h0;
    end else if (flush) begin
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign out_pc     = r_out_pc;
  assign drop_count = r_drop_count;

  assign instr_op  = r_out_instr[31:28];
  assign alu_op    = r_out_instr[27:24];
  assign branch_op = r_out_instr[3:1];
  assign areg      = r_out_instr[11:8];
  assign breg      = r_out_instr[7:4];
  assign dreg      = r_out_instr[3:0];
  assign he        = r_out_instr[8];
  assign oe        = r_out_instr[0];
  assign sig       = r_out_instr[0];

  assign const_alu = {{(DATA_WIDTH-16){r_out_instr[23]}}, r_out_instr[23:8]};
  assign const16   = {{(DATA_WIDTH-16){r_out_instr[27]}}, r_out_instr[27:12]};
  assign const16u  = {{(DATA_WIDTH-16){1'b0}}, r_out_instr[27:12]};
  assign const27   = {{(DATA_WIDTH-27){1'b0}}, r_out_instr[27:1]};

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode, streaming,
// back-pressure, flush accounting and reset with a full skid buffer.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [26:0] in_pc;

  logic        in_ready, out_valid, he, oe, sig;
  logic [26:0] out_pc;
  logic [3:0]  instr_op, alu_op, areg, breg, dreg;
  logic [2:0]  branch_op;
  logic [31:0] const_alu, const16, const16u, const27;
  logic [15:0] drop_count;

  logic        w64_in_ready, w64_out_valid, w64_he, w64_oe, w64_sig;
  logic [26:0] w64_out_pc;
  logic [3:0]  w64_instr_op, w64_alu_op, w64_areg, w64_breg, w64_dreg;
  logic [2:0]  w64_branch_op;
  logic [63:0] w64_const_alu, w64_const16, w64_const16u, w64_const27;
  logic [15:0] w64_drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .instr_op(instr_op), .alu_op(alu_op), .branch_op(branch_op),
    .const_alu(const_alu), .const16(const16), .const16u(const16u),
    .const27(const27), .areg(areg), .breg(breg), .dreg(dreg),
    .he(he), .oe(oe), .sig(sig), .drop_count(drop_count)
  );

  decode_stage #(.DATA_WIDTH(64), .PC_WIDTH(27)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(w64_in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(w64_out_valid), .out_ready(out_ready), .out_pc(w64_out_pc),
    .instr_op(w64_instr_op), .alu_op(w64_alu_op), .branch_op(w64_branch_op),
    .const_alu(w64_const_alu), .const16(w64_const16), .const16u(w64_const16u),
    .const27(w64_const27), .areg(w64_areg), .breg(w64_breg), .dreg(w64_dreg),
    .he(w64_he), .oe(w64_oe), .sig(w64_sig), .drop_count(w64_drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; in_pc = 27'h0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop got %h exp 0", drop_count); end
    checks++; if ({instr_op, alu_op, const16u, out_pc} !== '0) begin errors++; $display("FAIL reset_fields got op=%h alu=%h c16u=%h pc=%h exp 0", instr_op, alu_op, const16u, out_pc); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_decode();
    instr = 32'h3A8001F5; in_pc = 27'h100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 27'h100) begin errors++; $display("FAIL dec_valid_pc got v=%b pc=%h exp v=1 pc=100", out_valid, out_pc); end
    checks++; if ({instr_op, alu_op, 1'b0, branch_op} !== 12'h3A2) begin errors++; $display("FAIL dec_ops got op=%h alu=%h br=%h exp 3 a 2", instr_op, alu_op, branch_op); end
    checks++; if (const_alu !== 32'hFFFF8001) begin errors++; $display("FAIL dec_const_alu got %h exp ffff8001", const_alu); end
    checks++; if (const16 !== 32'hFFFFA800) begin errors++; $display("FAIL dec_const16 got %h exp ffffa800", const16); end
    checks++; if (const16u !== 32'h0000A800) begin errors++; $display("FAIL dec_const16u got %h exp 0000a800", const16u); end
    checks++; if (const27 !== 32'h054000FA) begin errors++; $display("FAIL dec_const27 got %h exp 054000fa", const27); end
    checks++; if ({areg, breg, dreg} !== 12'h1F5) begin errors++; $display("FAIL dec_regs got %h%h%h exp 1f5", areg, breg, dreg); end
    checks++; if ({he, oe, sig} !== 3'b111) begin errors++; $display("FAIL dec_flags got %b%b%b exp 111", he, oe, sig); end
    checks++; if (w64_const_alu !== 64'hFFFFFFFFFFFF8001) begin errors++; $display("FAIL dec64_const_alu got %h exp ffffffffffff8001", w64_const_alu); end
    checks++; if (w64_const27 !== 64'h00000000054000FA) begin errors++; $display("FAIL dec64_const27 got %h exp 00000000054000fa", w64_const27); end
    checks++; if (w64_const16 !== 64'hFFFFFFFFFFFFA800 || w64_const16u !== 64'h000000000000A800) begin errors++; $display("FAIL dec64_const16 got %h %h exp ffffffffffffa800 000000000000a800", w64_const16, w64_const16u); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] v;
    v = 32'h0; v[31:28] = 4'h0; v[3:0] = 4'h0;
    instr = v; in_pc = 27'h200; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 27'(32'h200 + i - 1)) begin errors++; $display("FAIL stream_%0d_pc got v=%b pc=%h exp %h", i, out_valid, out_pc, 27'(32'h200 + i - 1)); end
      checks++; if (instr_op !== 4'(i - 1) || dreg !== 4'(i - 1)) begin errors++; $display("FAIL stream_%0d_fields got op=%h d=%h exp %h", i, instr_op, dreg, 4'(i - 1)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_%0d_in_ready got %b exp 1", i, in_ready); end
      if (i < 8) begin
        v = 32'h0; v[31:28] = 4'(i); v[3:0] = 4'(i);
        instr = v; in_pc = 27'(32'h200 + i);
      end else begin
        in_valid = 1'b0;
      end
    end
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'hA0000001; in_pc = 27'h300;
    step();
    checks++; if (out_pc !== 27'h300 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_a got pc=%h rdy=%b exp 300 1", out_pc, in_ready); end
    instr = 32'hB0000002; in_pc = 27'h301;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 27'h300 || instr_op !== 4'hA || in_ready !== 1'b0) begin errors++; $display("FAIL bp_b_skid got v=%b pc=%h op=%h rdy=%b exp 1 300 a 0", out_valid, out_pc, instr_op, in_ready); end
    instr = 32'hC0000003; in_pc = 27'h302;
    step();
    checks++; if (out_pc !== 27'h300 || instr_op !== 4'hA || in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held got pc=%h op=%h rdy=%b exp 300 a 0", out_pc, instr_op, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 27'h301 || instr_op !== 4'hB || in_ready !== 1'b1) begin errors++; $display("FAIL bp_b_out got v=%b pc=%h op=%h rdy=%b exp 1 301 b 1", out_valid, out_pc, instr_op, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 27'h302 || instr_op !== 4'hC) begin errors++; $display("FAIL bp_c_out got v=%b pc=%h op=%h exp 1 302 c", out_valid, out_pc, instr_op); end
    step();
    checks++; if (out_valid !== 1'b0 || drop_count !== 16'h0) begin errors++; $display("FAIL bp_drain got v=%b drop=%h exp 0 0", out_valid, drop_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'hD0000000; in_pc = 27'h400;
    step();
    instr = 32'hE0000000; in_pc = 27'h401;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_count !== 16'd2) begin errors++; $display("FAIL flush_full got v=%b rdy=%b drop=%0d exp 0 1 2", out_valid, in_ready, drop_count); end
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'h5F000123; in_pc = 27'h410;
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 27'h410 || instr_op !== 4'h5 || alu_op !== 4'hF || areg !== 4'h1) begin errors++; $display("FAIL flush_after got v=%b pc=%h op=%h alu=%h a=%h exp 1 410 5 f 1", out_valid, out_pc, instr_op, alu_op, areg); end
    // OUT handshaken this cycle is delivered; only the accepted input drops.
    instr = 32'h60000000; in_pc = 27'h411; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || drop_count !== 16'd3) begin errors++; $display("FAIL flush_handshake got v=%b drop=%0d exp 0 3", out_valid, drop_count); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h7A8001F5; in_pc = 27'h500;
    step();
    instr = 32'h8A8001F5; in_pc = 27'h501;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstf_setup got rdy=%b exp 0", in_ready); end
    in_valid = 1'b0; reset = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || drop_count !== 16'h0) begin errors++; $display("FAIL rstf_state got v=%b rdy=%b drop=%h exp 0 0 0", out_valid, in_ready, drop_count); end
    checks++; if ({instr_op, alu_op, areg, breg, dreg, const_alu, const27, out_pc} !== '0) begin errors++; $display("FAIL rstf_fields got op=%h alu=%h ca=%h c27=%h pc=%h exp 0", instr_op, alu_op, const_alu, const27, out_pc); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstf_release got rdy=%b v=%b exp 1 0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the B32P-class CPU.
- Accepts fetched 32-bit instructions and their PC on a valid/ready handshake.
- Splits each instruction into opcode, ALU op, branch op, register indices, flags and constants, with constants extended to DATA_WIDTH.
- Contains a one-entry skid buffer so back-pressure costs no throughput. Supports pipeline flush. Sits between fetch and the register-read/execute stage.

Parameters:
- DATA_WIDTH, 32: width of the sign/zero-extended constant outputs; must be ≥ 32.
- PC_WIDTH, 27: width of the PC carried alongside each instruction.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  instr/in_pc valid
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- in_pc  in  PC_WIDTH  PC of instr
- out_valid  out  1  decoded outputs valid
- out_ready  in  1  downstream accepts this cycle
- out_pc  out  PC_WIDTH  PC of decoded instruction
- instr_op  out  4  instr[31:28]
- alu_op  out  4  instr[27:24]
- branch_op  out  3  instr[3:1]
- const_alu  out  DATA_WIDTH  sign-extend instr[23:8]
- const16  out  DATA_WIDTH  sign-extend instr[27:12]
- const16u  out  DATA_WIDTH  zero-extend instr[27:12]
- const27  out  DATA_WIDTH  zero-extend instr[27:1]
- areg, breg, dreg  out  4 each  instr[11:8], instr[7:4], instr[3:0]
- he  out  1  instr[8] (loadhi high-enable)
- oe  out  1  instr[0] (jump offset-enable)
- sig  out  1  instr[0] (signed branch compare)
- drop_count  out  16  instructions discarded by flush, saturating

Behaviour:
- All decode fields are registered: valid decode appears on outputs 1 cycle after acceptance (in_valid && in_ready).
- Storage is output register (OUT) plus skid register (SKID). Each holds instr, pc and a valid bit. Decoded fields are computed combinationally from the OUT instr register.
- in_ready = !skid_valid, driven from a register. It is 0 while reset is asserted.
- Transfer rules per cycle, with no flush:
  - OUT empty or (out_valid && out_ready): OUT loads from SKID if skid_valid, else from the input if accepted. If SKID fed OUT, an accepted input goes to SKID.
  - OUT full and !out_ready: an accepted input goes to SKID.
  - In-order delivery is always preserved.
- States (skid_valid, out_valid):
  - EMPTY (0,0)
  - ONE (0,1)
  - FULL (1,1)
  - (1,0) is illegal and must never occur.
  - Steady in_valid=out_ready=1 gives one instruction per cycle, staying in ONE.
- Flush:
  - Next cycle out_valid=0 and skid_valid=0.
  - An input accepted in the flush cycle is discarded.
  - in_ready=1 next cycle.
  - drop_count += number of valid entries discarded (OUT + SKID + accepted input, 0..3), saturating at 0xFFFF.
  - flush has priority over out_ready. An OUT entry handshaken in the same cycle still counts as delivered, not dropped.
- Outputs while out_valid=0 hold their last values (don't-care for the consumer). Verification checks fields only when out_valid=1.
- Reset:
  - out_valid=0, skid_valid=0, in_ready=0, drop_count=0.
  - OUT instr=0, so all fields read 0. out_pc=0.
  - Reset mid-transfer drops everything without counting.
- Outputs must be stable while out_valid && !out_ready.
- Extension: bits [DATA_WIDTH-1:16] of const_alu/const16 replicate the source sign bit. const16u/const27 upper bits are 0.

Test Plan:
- Decode check: reset, then instr=0x3A8001F5, pc=0x100, out_ready=1. Next cycle requires:
  - out_valid=1, out_pc=0x100, instr_op=3, alu_op=0xA, branch_op=2
  - const_alu=0xFFFF8001, const16=0xFFFFA800, const16u=0x0000A800, const27=0x054000FA
  - areg=1, breg=0xF, dreg=5, he=1, oe=1, sig=1
- DATA_WIDTH=64 with the same instruction: const_alu=0xFFFFFFFFFFFF8001, const27=0x00000000054000FA.
- Streaming: 8 back-to-back instructions with out_ready=1. Requires one output per cycle in order, in_ready never drops.
- Back-pressure: hold out_ready=0 while sending A, B, C. Requires A on outputs, B in SKID, in_ready=0 after B, C held off. Release out_ready: A, B, C appear on consecutive cycles.
- Flush in FULL state with in_valid=0 and out_ready=0. Requires next cycle out_valid=0, in_ready=1, drop_count=2. A subsequent instruction decodes normally.
- Reset asserted with SKID full. Requires next cycle out_valid=0, all fields 0, drop_count=0, in_ready=0. in_ready=1 on the first cycle after reset deasserts.
